// File: rtl/uart_tx_framer.sv
// UART transmitter running on the system clock: ready/valid payload in, serial
// frame out (start, DATA_BITS LSB first, optional parity, 1 or 2 stop bits).
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_valid,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2:0]           state_dbg
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 2);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_framer: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_framer: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_framer: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  // Handshake: a payload transfers on a rising edge with i_valid && o_ready;
  // o_ready is high only in IDLE, so valid while busy is simply ignored.
  assign o_ready   = (state_q == S_IDLE);
  assign o_busy    = ~o_ready;
  assign o_tx      = tx_q;
  assign o_done    = done_q;
  assign state_dbg = state_q;
  assign bit_end   = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    // tx_d is the level of the next bit, so the line changes on the boundary edge.
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (i_valid) begin
          state_d = S_START;
          cnt_d   = '0;
          idx_d   = '0;
          stop_d  = 1'b0;
          sh_d    = i_data;
          par_d   = (^i_data) ^ ODD;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_MAX) begin
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + IW'(1);
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Parametrised UART transmitter that replaces the fixed 8N1, derived-clock transmitter. Runs entirely on the system clock, using an internal bit-period counter instead of a divided clock. Data width, parity mode and stop-bit count are configurable. A ready/valid handshake lets it connect directly to a FIFO or register-bank source in the UART subsystem.

## Interface
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range ≥ 2.
- DATA_BITS, 8: payload bits per frame; legal range 5–9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd; other values illegal.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.
- Illegal parameter values fail elaboration ($error in a generate check).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  source has a byte to send.
- i_data  in  DATA_BITS  payload; sampled only on the handshake edge.
- o_ready  out  1  block can accept a payload; high only in IDLE.
- o_tx  out  1  serial line, registered; idle-high.
- o_busy  out  1  frame in progress (any state other than IDLE).
- o_done  out  1  one-cycle pulse when the final stop bit completes.

## Operation
- States and transitions:
  - IDLE → START on handshake.
  - START → DATA.
  - DATA → PARITY when PARITY ≠ 0; DATA → STOP when PARITY = 0.
  - PARITY → STOP.
  - STOP → IDLE.
- Handshake: a payload is accepted on a rising edge where i_valid && o_ready. i_valid while busy is ignored. There is no queueing.
- On acceptance, i_data is captured into an internal shift register. Later changes to i_data have no effect on the frame.
- Bits go out LSB first. Each bit (start, data, parity, stop) is held for exactly CLKS_PER_BIT cycles.
- Line levels: start bit = 0, stop bits = 1.
- Parity bit is computed from the captured data: even → XOR of the data bits; odd → inverted XOR.
- Frame length: N = 1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS bits.
- Counter widths:
  - Bit-period counter: $clog2(CLKS_PER_BIT) bits; counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Bit index: $clog2(DATA_BITS + 1) bits.
  - Stop-bit counter: 1 bit.
  - No other arithmetic.
- o_ready is decoded from state (state == IDLE). o_busy = ~o_ready.
- Reset values: state IDLE, o_tx = 1, o_ready = 1, o_busy = 0, o_done = 0, all counters 0, shift register 0.
- Reset mid-frame: o_tx returns to 1 asynchronously and the frame is abandoned. No o_done is issued. The first edge after release sees IDLE.

## Timing
- Let E0 be the handshake edge.
- o_tx goes low at E0 (visible in the cycle after the handshake cycle) and stays low until edge E0 + CLKS_PER_BIT.
- Bit k (k = 0 is the start bit) occupies edges E0 + k·CLKS_PER_BIT through E0 + (k+1)·CLKS_PER_BIT − 1.
- At edge E0 + N·CLKS_PER_BIT:
  - state returns to IDLE;
  - o_done is set for exactly one cycle;
  - o_ready and o_tx = 1 are already in effect.
- Back-to-back: if i_valid is held high, the next handshake occurs at E0 + N·CLKS_PER_BIT + 1 edge. The minimum idle-high time between frames is therefore the stop bit(s) plus 1 clk.
- Throughput: one frame per N·CLKS_PER_BIT + 1 cycles.
- o_done and a new handshake never occur on the same edge.

## Test plan
- **Reset state:** assert reset_n = 0 at a random time → o_tx = 1, o_ready = 1, o_busy = 0, o_done = 0 immediately.
- **8N1 baseline** (defaults, CLKS_PER_BIT = 4): send 0xA5 → o_tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. o_done pulses once, 40 cycles after E0. o_ready stays low for those 40 cycles.
- **Parity, 2 stop bits** (DATA_BITS = 7, STOP_BITS = 2, CLKS_PER_BIT = 4):
  - PARITY = 1 (even), send 0x41 → parity bit = 0; frame = 11 bits = 44 cycles.
  - PARITY = 2 (odd), same byte → parity bit = 1.
- **Back-to-back:** hold i_valid high and supply 0x00 then 0xFF (8N1, CLKS_PER_BIT = 4) → the second start bit begins exactly 41 cycles after the first E0. Both frames are bit-exact. Two o_done pulses occur.
- **Ignored inputs during a frame:** toggle i_data and pulse i_valid while o_busy → transmitted bits match the captured byte, and no extra frame follows.
- **Reset mid-frame:** assert reset_n during data bit 3 → o_tx = 1 at once and no o_done. After release, a new 0x3C frame transmits correctly.
